spi_slave_responder: RTL and testbench
======================================

# spi_slave_responder

Slave-side SPI engine for the APB-to-SPI core: when the core is configured as slave (mstr_i=0), it receives serial bytes from an external master on SCLK/MOSI under SS, shifts transmit data out on MISO, and hands completed bytes to the register block. It is the counterpart of the master-side slave-select/transfer timing logic. All external SPI pins are oversampled in the PCLK domain; no logic runs on SCLK.

## Interface
- No parameters; frame width fixed at 8 bits.
- PCLK  input  1  system clock
- PRESET_n  input  1  asynchronous, active-low reset
- mstr_i  input  1  1 = master mode (block idle), 0 = slave mode
- spiswai_i  input  1  SPI stop-in-wait control
- spi_mode_i  input  2  00 run, 01 wait, 10/11 stop
- cpol_i, cpha_i  input  1 each  clock polarity / phase
- lsbfe_i  input  1  1 = LSB first, 0 = MSB first
- ss_i, sclk_i, mosi_i  input  1 each  raw SPI pins (asynchronous)
- miso_o  output  1  serial data out
- miso_oe_o  output  1  MISO drive enable
- data_tx_i  input  8  byte to transmit
- send_data_i  input  1  one-cycle load strobe for data_tx_i
- rx_read_i  input  1  one-cycle strobe: register block has read data_rx_o
- data_rx_o  output  8  last completed received byte
- receive_data_o  output  1  one-PCLK pulse per completed byte
- tip_o  output  1  transfer in progress
- overrun_o  output  1  sticky overrun flag (see Configuration)

## Operation
- Enable: active = !mstr_i && (spi_mode_i==00 || (spi_mode_i==01 && !spiswai_i)). Inactive: state IDLE, miso_oe_o=0, counters cleared; data_rx_o retained.
- ss_i, sclk_i, mosi_i each pass a 2-flop synchronizer; sclk and ss edges detected from synchronized value vs. one-cycle-delayed copy.
- Leading edge = rising if cpol_i=0, falling if cpol_i=1; trailing edge is the opposite.
- Sample edge: leading if cpha_i=0, trailing if cpha_i=1. Shift edge: the other one.
- tx holding register: loaded from data_tx_i on send_data_i; retains value otherwise (reset 8'hFF).
- States:
  - IDLE: SS synchronized high. On SS falling edge while active -> ARMED; copy holding register into tx shift register, bit count=0.
  - ARMED: miso_oe_o=1. cpha_i=0: first bit already on miso_o. cpha_i=1: first bit driven on first leading (shift) edge. First sample edge -> SHIFT.
  - SHIFT: each sample edge captures mosi into rx shift register, count+1; each shift edge advances miso_o. 8th sample -> DONE.
  - DONE (one cycle): data_rx_o <= rx shift register, receive_data_o=1, count=0, reload tx shift register from holding register; -> ARMED if SS still low, else IDLE.
- Bit order per lsbfe_i, sampled at SS falling edge and held for the frame.
- SS rising mid-byte or leaving active mid-byte: abort -> IDLE, no receive_data_o, partial byte discarded, miso_oe_o=0 next cycle.
- SS rising in the same cycle as 8th sample: byte completes (DONE), then IDLE.
- send_data_i during a byte updates only the holding register; takes effect next frame.
- tip_o = 1 in ARMED/SHIFT/DONE, 0 in IDLE.

## Timing
- Reset: miso_o=1, miso_oe_o=0, data_rx_o=8'h00, receive_data_o=0, tip_o=0, overrun_o=0, state IDLE.
- Pin-to-edge-detect latency: 3 PCLK (2 sync + 1 compare).
- tip_o rises 1 PCLK after SS falling edge is detected.
- data_rx_o and receive_data_o update together, 1 PCLK after detecting the 8th sample edge.
- Requirement on the external master: SCLK high and low phases each >= 4 PCLK.
- Reset asserted mid-transfer forces all reset values immediately (asynchronous).

## Configuration
- SPI_SLV_OVERRUN_EN defined: an internal rx_full flag is set in DONE and cleared by rx_read_i. DONE with rx_full already set sets overrun_o (sticky) and still overwrites data_rx_o. overrun_o is cleared by rx_read_i; a simultaneous DONE and rx_read_i leaves rx_full=1 and overrun_o=0.
- Undefined: no rx_full flag; overrun_o tied to 0.

## Structure
- Shared package spi_pkg: slave state enum (IDLE, ARMED, SHIFT, DONE), spi_mode encodings (RUN=00, WAIT=01), frame width constant 8.
- One sub-module, spi_sync_edge: 2-flop synchronizer plus rise/fall detect; instantiated three times (ss, sclk, mosi; edge outputs unused for mosi).

## Test plan
- Mode 0 (cpol=0, cpha=0), MSB first, master sends 8'hA5, tx=8'h3C -> data_rx_o=8'hA5 with one receive_data_o pulse; MISO bits 0,0,1,1,1,1,0,0.
- Mode 3, LSB first, master sends 8'h81, tx=8'hF0 -> data_rx_o=8'h81; MISO sequence LSB first 0,0,0,0,1,1,1,1.
- Two back-to-back bytes 8'h11, 8'h22 with SS held low, send_data_i loads 8'h55 mid first byte -> two pulses; second MISO byte is 8'h55.
- SS raised after 5 bits -> no receive_data_o, data_rx_o unchanged, tip_o=0, miso_oe_o=0.
- mstr_i=1, or spi_mode_i=01 with spiswai_i=1, during SS-low traffic -> tip_o stays 0, no pulses.
- With SPI_SLV_OVERRUN_EN: two bytes, no rx_read_i -> overrun_o=1 and data_rx_o equals the second byte; rx_read_i -> overrun_o=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI core: slave FSM states, spi_mode encodings, frame width
// and bit-order helpers for the shift registers.
package spi_pkg;

   localparam int unsigned FrameWidth = 8;
   localparam int unsigned CntWidth   = 3;

   localparam logic [1:0] SpiModeRun  = 2'b00;
   localparam logic [1:0] SpiModeWait = 2'b01;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StShift,
      StDone
   } slv_state_e;

   function automatic logic tx_first_bit(input logic [FrameWidth-1:0] data, input logic lsb);
      return lsb ? data[0] : data[FrameWidth-1];
   endfunction

   // Vacated positions fill with 1 so an exhausted register idles MISO high.
   function automatic logic [FrameWidth-1:0] tx_shift(input logic [FrameWidth-1:0] data,
                                                      input logic lsb);
      return lsb ? {1'b1, data[FrameWidth-1:1]} : {data[FrameWidth-2:0], 1'b1};
   endfunction

   function automatic logic [FrameWidth-1:0] rx_shift(input logic [FrameWidth-1:0] data,
                                                      input logic lsb, input logic din);
      return lsb ? {din, data[FrameWidth-1:1]} : {data[FrameWidth-2:0], din};
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, plus rise/fall detection against a
// one-cycle-delayed copy of the synchronized level.
module spi_sync_edge #(
   parameter logic ResetVal = 1'b0
) (
   input  logic PCLK,
   input  logic PRESET_n,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   // [1:0] synchronizer stages, [2] delayed copy for edge detection
   logic [2:0] sync_q;

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         sync_q <= {3{ResetVal}};
      end else begin
         sync_q <= {sync_q[1:0], d_i};
      end
   end

   assign q_o    = sync_q[1];
   assign rise_o = sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave_responder.sv
// Slave-side SPI engine: oversamples SS/SCLK/MOSI in the PCLK domain, shifts MISO, delivers bytes.
// Optional overrun detection is enabled by defining SPI_SLV_OVERRUN_EN.
module spi_slave_responder
   import spi_pkg::*;
(
   input  logic                  PCLK,
   input  logic                  PRESET_n,
   input  logic                  mstr_i,
   input  logic                  spiswai_i,
   input  logic [1:0]            spi_mode_i,
   input  logic                  cpol_i,
   input  logic                  cpha_i,
   input  logic                  lsbfe_i,
   input  logic                  ss_i,
   input  logic                  sclk_i,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic                  miso_oe_o,
   input  logic [FrameWidth-1:0] data_tx_i,
   input  logic                  send_data_i,
   input  logic                  rx_read_i,
   output logic [FrameWidth-1:0] data_rx_o,
   output logic                  receive_data_o,
   output logic                  tip_o,
   output logic                  overrun_o
);

   localparam logic [CntWidth-1:0] LastBit = CntWidth'(FrameWidth - 1);

   logic ss_s, ss_fall, ss_rise, sclk_s, sclk_rise, sclk_fall, mosi_s, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_sync_edge #(.ResetVal(1'b1)) u_sync_ss (
      .PCLK    (PCLK),
      .PRESET_n(PRESET_n),
      .d_i     (ss_i),
      .q_o     (ss_s),
      .rise_o  (ss_rise),
      .fall_o  (ss_fall)
   );

   spi_sync_edge #(.ResetVal(1'b0)) u_sync_sclk (
      .PCLK    (PCLK),
      .PRESET_n(PRESET_n),
      .d_i     (sclk_i),
      .q_o     (sclk_s),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_sync_edge #(.ResetVal(1'b0)) u_sync_mosi (
      .PCLK    (PCLK),
      .PRESET_n(PRESET_n),
      .d_i     (mosi_i),
      .q_o     (mosi_s),
      .rise_o  (mosi_rise),
      .fall_o  (mosi_fall)
   );

   assign unused_sync = ss_rise ^ sclk_s ^ mosi_rise ^ mosi_fall;

   slv_state_e            state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [FrameWidth-1:0] tx_hold_q, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, data_rx_q, data_rx_d;
   logic                  miso_q, miso_d, lsbfe_q, lsbfe_d;

   logic                  active, lead_edge, trail_edge, sample_edge, shift_edge, lsb_sel;
   logic [FrameWidth-1:0] load_sr, rx_next;
   logic                  load_miso;

   assign active = !mstr_i && ((spi_mode_i == SpiModeRun) ||
                               ((spi_mode_i == SpiModeWait) && !spiswai_i));

   assign lead_edge   = cpol_i ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol_i ? sclk_rise : sclk_fall;
   assign sample_edge = cpha_i ? trail_edge : lead_edge;
   assign shift_edge  = cpha_i ? lead_edge : trail_edge;

   // Bit order is taken live at frame start, then held in lsbfe_q for the rest of the frame.
   assign lsb_sel   = (state_q == StIdle) ? lsbfe_i : lsbfe_q;
   assign load_sr   = cpha_i ? tx_hold_q : tx_shift(tx_hold_q, lsb_sel);
   assign load_miso = cpha_i ? miso_q : tx_first_bit(tx_hold_q, lsb_sel);
   assign rx_next   = rx_shift(rx_sr_q, lsbfe_q, mosi_s);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      data_rx_d = data_rx_q;
      miso_d    = miso_q;
      lsbfe_d   = lsbfe_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (active && ss_fall) begin
               state_d = StArmed;
               lsbfe_d = lsbfe_i;
               tx_sr_d = load_sr;
               miso_d  = load_miso;
            end
         end
         StArmed, StShift: begin
            if (!active) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (sample_edge && (cnt_q == LastBit)) begin
               // A completing sample wins over a simultaneous SS release.
               state_d   = StDone;
               cnt_d     = '0;
               rx_sr_d   = rx_next;
               data_rx_d = rx_next;
            end else if (ss_s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (sample_edge) begin
               state_d = StShift;
               cnt_d   = cnt_q + 1'b1;
               rx_sr_d = rx_next;
            end else if (shift_edge && (cpha_i || (state_q == StShift))) begin
               // With cpha=0 the trailing edge before the first sample must not shift.
               miso_d  = tx_first_bit(tx_sr_q, lsbfe_q);
               tx_sr_d = tx_shift(tx_sr_q, lsbfe_q);
            end
         end
         StDone: begin
            tx_sr_d = load_sr;
            miso_d  = load_miso;
            state_d = (ss_s || !active) ? StIdle : StArmed;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         tx_hold_q <= 8'hFF;
         tx_sr_q   <= 8'hFF;
         rx_sr_q   <= '0;
         data_rx_q <= '0;
         miso_q    <= 1'b1;
         lsbfe_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         data_rx_q <= data_rx_d;
         miso_q    <= miso_d;
         lsbfe_q   <= lsbfe_d;
         if (send_data_i) begin
            tx_hold_q <= data_tx_i;
         end
      end
   end

   assign miso_o         = miso_q;
   assign miso_oe_o      = (state_q != StIdle);
   assign tip_o          = (state_q != StIdle);
   assign receive_data_o = (state_q == StDone);
   assign data_rx_o      = data_rx_q;

`ifdef SPI_SLV_OVERRUN_EN
   logic rx_full_q, rx_full_d, overrun_q, overrun_d;

   always_comb begin
      rx_full_d = rx_full_q;
      overrun_d = overrun_q;
      if (receive_data_o) begin
         rx_full_d = 1'b1;
      end else if (rx_read_i) begin
         rx_full_d = 1'b0;
      end
      if (rx_read_i) begin
         overrun_d = 1'b0;
      end else if (receive_data_o && rx_full_q) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         rx_full_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         rx_full_q <= rx_full_d;
         overrun_q <= overrun_d;
      end
   end

   assign overrun_o = overrun_q;
`else
   logic unused_rx_read;
   assign unused_rx_read = rx_read_i;
   assign overrun_o      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: an SPI master model drives the pins, received bytes
// are checked through a scoreboard queue; overrun checks follow SPI_SLV_OVERRUN_EN.
module tb_spi_slave_responder;

   localparam int H = 6;  // PCLK cycles per SCLK half period

   logic       PCLK = 1'b0;
   logic       PRESET_n;
   logic       mstr_i, spiswai_i, cpol_i, cpha_i, lsbfe_i, ss_i, sclk_i, mosi_i;
   logic [1:0] spi_mode_i;
   logic       miso_o, miso_oe_o, send_data_i, rx_read_i, receive_data_o, tip_o, overrun_o;
   logic [7:0] data_tx_i, data_rx_o;

   int         errors = 0;
   int         checks = 0;
   int         pulses = 0;
   int         pulses_before;
   logic [7:0] exp_q[$];

   always #5 PCLK = ~PCLK;

   spi_slave_responder dut (
      .PCLK          (PCLK),
      .PRESET_n      (PRESET_n),
      .mstr_i        (mstr_i),
      .spiswai_i     (spiswai_i),
      .spi_mode_i    (spi_mode_i),
      .cpol_i        (cpol_i),
      .cpha_i        (cpha_i),
      .lsbfe_i       (lsbfe_i),
      .ss_i          (ss_i),
      .sclk_i        (sclk_i),
      .mosi_i        (mosi_i),
      .miso_o        (miso_o),
      .miso_oe_o     (miso_oe_o),
      .data_tx_i     (data_tx_i),
      .send_data_i   (send_data_i),
      .rx_read_i     (rx_read_i),
      .data_rx_o     (data_rx_o),
      .receive_data_o(receive_data_o),
      .tip_o         (tip_o),
      .overrun_o     (overrun_o)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   // Scoreboard: every receive_data_o pulse must match the oldest byte the master sent.
   always @(negedge PCLK) begin
      if (PRESET_n && receive_data_o) begin
         pulses++;
         chk("rx_pulse_expected", {7'b0, exp_q.size() != 0}, 8'd1);
         if (exp_q.size() != 0) chk("rx_byte", data_rx_o, exp_q.pop_front());
      end
   end

   task automatic load_tx(input logic [7:0] b);
      data_tx_i   = b;
      send_data_i = 1'b1;
      tick(1);
      send_data_i = 1'b0;
   endtask

   task automatic pulse_read();
      rx_read_i = 1'b1;
      tick(1);
      rx_read_i = 1'b0;
      tick(1);
   endtask

   task automatic ss_low();
      ss_i = 1'b0;
      tick(H);
   endtask

   task automatic ss_high();
      ss_i = 1'b1;
      tick(H);
   endtask

   // One SCLK period; MISO is checked just before the sample edge, as a master would.
   task automatic spi_bit(input logic mbit, input logic exp_miso, input bit do_chk,
                          input logic exp_tip, input string tag);
      if (!cpha_i) begin
         mosi_i = mbit;
         tick(H);
      end else begin
         sclk_i = ~cpol_i;
         mosi_i = mbit;
         tick(H);
      end
      chk({tag, "_tip"}, {7'b0, tip_o}, {7'b0, exp_tip});
      if (do_chk) begin
         chk(tag, {7'b0, miso_o}, {7'b0, exp_miso});
         chk({tag, "_oe"}, {7'b0, miso_oe_o}, 8'd1);
      end
      if (!cpha_i) begin
         sclk_i = ~cpol_i;
         tick(H);
         sclk_i = cpol_i;
      end else begin
         sclk_i = cpol_i;
         tick(H);
      end
   endtask

   task automatic xfer(input logic [7:0] mbyte, input logic [7:0] txbyte, input string tag);
      exp_q.push_back(mbyte);
      for (int i = 0; i < 8; i++) begin
         spi_bit(lsbfe_i ? mbyte[i] : mbyte[7-i], lsbfe_i ? txbyte[i] : txbyte[7-i], 1'b1, 1'b1,
                 tag);
      end
   endtask

   task automatic set_mode(input logic pol, input logic pha, input logic lsb);
      cpol_i  = pol;
      cpha_i  = pha;
      lsbfe_i = lsb;
      sclk_i  = pol;
      tick(H);
   endtask

   initial begin
      PRESET_n    = 1'b0;
      mstr_i      = 1'b0;
      spiswai_i   = 1'b0;
      spi_mode_i  = 2'b00;
      cpol_i      = 1'b0;
      cpha_i      = 1'b0;
      lsbfe_i     = 1'b0;
      ss_i        = 1'b1;
      sclk_i      = 1'b0;
      mosi_i      = 1'b0;
      data_tx_i   = 8'h00;
      send_data_i = 1'b0;
      rx_read_i   = 1'b0;
      tick(3);
      chk("rst_miso", {7'b0, miso_o}, 8'd1);
      chk("rst_oe", {7'b0, miso_oe_o}, 8'd0);
      chk("rst_rx", data_rx_o, 8'h00);
      chk("rst_rcv", {7'b0, receive_data_o}, 8'd0);
      chk("rst_tip", {7'b0, tip_o}, 8'd0);
      chk("rst_ovr", {7'b0, overrun_o}, 8'd0);
      PRESET_n = 1'b1;
      tick(3);

      // Mode 0, MSB first
      load_tx(8'h3C);
      ss_low();
      xfer(8'hA5, 8'h3C, "m0_miso");
      ss_high();
      chk("m0_rx", data_rx_o, 8'hA5);
      chk("m0_tip_end", {7'b0, tip_o}, 8'd0);
      chk("m0_pulses", 8'(pulses), 8'd1);

      // Mode 3, LSB first
      set_mode(1'b1, 1'b1, 1'b1);
      load_tx(8'hF0);
      ss_low();
      xfer(8'h81, 8'hF0, "m3_miso");
      ss_high();
      chk("m3_rx", data_rx_o, 8'h81);

      // Back-to-back bytes, holding register reloaded mid first byte
      set_mode(1'b0, 1'b0, 1'b0);
      load_tx(8'hAA);
      pulses_before = pulses;
      ss_low();
      fork
         xfer(8'h11, 8'hAA, "b2b0_miso");
         begin
            tick(5 * H);
            load_tx(8'h55);
         end
      join
      xfer(8'h22, 8'h55, "b2b1_miso");
      ss_high();
      chk("b2b_rx", data_rx_o, 8'h22);
      chk("b2b_pulses", 8'(pulses - pulses_before), 8'd2);
`ifndef SPI_SLV_OVERRUN_EN
      chk("no_ovr_feature", {7'b0, overrun_o}, 8'd0);
`endif

      // Abort after 5 bits
      pulses_before = pulses;
      ss_low();
      for (int i = 0; i < 5; i++) spi_bit(1'(i), 1'b0, 1'b0, 1'b1, "abort");
      ss_high();
      chk("abort_tip", {7'b0, tip_o}, 8'd0);
      chk("abort_oe", {7'b0, miso_oe_o}, 8'd0);
      chk("abort_rx", data_rx_o, 8'h22);
      chk("abort_pulses", 8'(pulses - pulses_before), 8'd0);

      // Inactive: master mode, then wait mode with spiswai set
      pulses_before = pulses;
      mstr_i = 1'b1;
      ss_low();
      for (int i = 0; i < 8; i++) spi_bit(1'b1, 1'b0, 1'b0, 1'b0, "mstr");
      ss_high();
      mstr_i     = 1'b0;
      spi_mode_i = 2'b01;
      spiswai_i  = 1'b1;
      ss_low();
      for (int i = 0; i < 8; i++) spi_bit(1'b1, 1'b0, 1'b0, 1'b0, "swai");
      ss_high();
      chk("inactive_pulses", 8'(pulses - pulses_before), 8'd0);
      chk("inactive_rx", data_rx_o, 8'h22);

      // Wait mode without spiswai stays active
      spiswai_i = 1'b0;
      ss_low();
      xfer(8'h5A, 8'h55, "wait_miso");
      ss_high();
      chk("wait_rx", data_rx_o, 8'h5A);
      spi_mode_i = 2'b00;

`ifdef SPI_SLV_OVERRUN_EN
      pulse_read();
      chk("ovr_clear0", {7'b0, overrun_o}, 8'd0);
      ss_low();
      xfer(8'hC3, 8'h55, "ovr0_miso");
      xfer(8'h3C, 8'h55, "ovr1_miso");
      ss_high();
      chk("ovr_set", {7'b0, overrun_o}, 8'd1);
      chk("ovr_rx", data_rx_o, 8'h3C);
      pulse_read();
      chk("ovr_clear1", {7'b0, overrun_o}, 8'd0);
`endif

      // Asynchronous reset mid-transfer
      ss_low();
      for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, 1'b0, 1'b1, "prerst");
      PRESET_n = 1'b0;
      #1;
      chk("arst_tip", {7'b0, tip_o}, 8'd0);
      chk("arst_oe", {7'b0, miso_oe_o}, 8'd0);
      chk("arst_miso", {7'b0, miso_o}, 8'd1);
      chk("arst_rx", data_rx_o, 8'h00);
      ss_i = 1'b1;
      tick(2);
      PRESET_n = 1'b1;
      tick(H);

      chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
